// File: rtl/multi_bank_buffer_control.sv
// Ping-pong / multi-bank buffer sequencer: tracks FREE/FILLING/READY/DRAINING per bank
// plus a frame-last flag. Optional error status outputs when MBBC_ERR_STATUS_EN is defined.
module multi_bank_buffer_control #(
  parameter int NUM_BANKS = 2,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_done_wr,
  input  logic                 i_done_wr_early,
  input  logic                 i_tlast,
  input  logic                 i_done_rd,
  output logic [NUM_BANKS-1:0] o_bank_wr_en,
  output logic [NUM_BANKS-1:0] o_bank_rd_en,
  output logic [IDX_W-1:0]     o_wr_idx,
  output logic [IDX_W-1:0]     o_rd_idx,
  output logic                 o_rd_last,
  output logic                 o_stall_axi_b,
  output logic [IDX_W:0]       o_ready_cnt
`ifdef MBBC_ERR_STATUS_EN
  ,
  output logic                 o_err_sticky,
  output logic [15:0]          o_err_cnt
`endif
);

  typedef enum logic [1:0] {FREE, FILLING, READY, DRAINING} bank_state_t;

  bank_state_t          r_state [NUM_BANKS];
  logic [NUM_BANKS-1:0] r_last;
  logic [IDX_W-1:0]     r_wr_idx;
  logic [IDX_W-1:0]     r_rd_idx;
  logic                 r_stall_early;

  logic                 w_wr_fire;
  logic                 w_rd_fire;
  logic [IDX_W-1:0]     w_wr_inc;
  logic [IDX_W-1:0]     w_rd_inc;
  logic [IDX_W-1:0]     w_fill_idx;
  logic                 w_fill_ok;
  logic                 w_peer_free;

  assign w_wr_fire = i_done_wr && (r_state[r_wr_idx] == FILLING);
  assign w_rd_fire = i_done_rd && (r_state[r_rd_idx] == DRAINING);
  assign w_wr_inc  = (r_wr_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : r_wr_idx + 1'b1;
  assign w_rd_inc  = (r_rd_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : r_rd_idx + 1'b1;

  // The bank that should be filling after this edge; a bank freed by the reader
  // on the same edge may be claimed immediately.
  assign w_fill_idx  = w_wr_fire ? w_wr_inc : r_wr_idx;
  assign w_fill_ok   = (r_state[w_fill_idx] == FREE) ||
                       (w_rd_fire && (r_rd_idx == w_fill_idx));
  assign w_peer_free = (r_state[w_wr_inc] == FREE) ||
                       (w_rd_fire && (r_rd_idx == w_wr_inc));

  // Later non-blocking writes to the same bank take priority (free -> refill).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i] <= (i == 0) ? FILLING : FREE;
      end
      r_last        <= '0;
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_stall_early <= 1'b0;
    end else begin
      if (w_rd_fire) begin
        r_state[r_rd_idx] <= FREE;
        r_last[r_rd_idx]  <= 1'b0;
        r_rd_idx          <= w_rd_inc;
      end else if (r_state[r_rd_idx] == READY) begin
        r_state[r_rd_idx] <= DRAINING;
      end
      if (w_wr_fire) begin
        r_state[r_wr_idx] <= READY;
        r_last[r_wr_idx]  <= i_tlast;
        r_wr_idx          <= w_wr_inc;
      end
      if (w_fill_ok) begin
        r_state[w_fill_idx] <= FILLING;
      end
      if (w_wr_fire || w_peer_free) begin
        r_stall_early <= 1'b0;
      end else if (i_done_wr_early) begin
        r_stall_early <= 1'b1;
      end
    end
  end

  always_comb begin
    o_bank_wr_en = '0;
    o_bank_rd_en = '0;
    o_rd_last    = 1'b0;
    o_ready_cnt  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      o_bank_wr_en[i] = (r_state[i] == FILLING);
      o_bank_rd_en[i] = (r_state[i] == DRAINING);
      if ((r_state[i] == DRAINING) && r_last[i]) begin
        o_rd_last = 1'b1;
      end
      if ((r_state[i] == READY) || (r_state[i] == DRAINING)) begin
        o_ready_cnt = o_ready_cnt + 1'b1;
      end
    end
  end

  assign o_wr_idx      = r_wr_idx;
  assign o_rd_idx      = r_rd_idx;
  assign o_stall_axi_b = r_stall_early | ~(|o_bank_wr_en);

`ifdef MBBC_ERR_STATUS_EN
  logic        r_err_sticky;
  logic [15:0] r_err_cnt;
  logic        w_wr_ign;
  logic        w_rd_ign;
  logic [16:0] w_err_sum;

  assign w_wr_ign  = i_done_wr & ~w_wr_fire;
  assign w_rd_ign  = i_done_rd & ~w_rd_fire;
  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_wr_ign) + 17'(w_rd_ign);

  // Counter saturates rather than wrapping so a long-running fault stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (w_wr_ign || w_rd_ign) begin
        r_err_sticky <= 1'b1;
      end
      r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign o_err_sticky = r_err_sticky;
  assign o_err_cnt    = r_err_cnt;
`endif

endmodule

// File: doc/multi_bank_buffer_control.md
MULTI_BANK_BUFFER_CONTROL -- requirements
Module: multi_bank_buffer_control

Interface
REQ-001 Parameter NUM_BANKS, default 2, number of buffer banks; legal range 2..8.
REQ-002 Parameter IDX_W, default $clog2(NUM_BANKS), bank index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 done_wr  input  1  single-cycle pulse: current write bank filled.
REQ-006 done_wr_early  input  1  single-cycle pulse: current write bank nearly full.
REQ-007 tlast  input  1  qualifies done_wr: bank holds end of frame.
REQ-008 done_rd  input  1  single-cycle pulse: current read bank drained.
REQ-009 bank_wr_en  output  NUM_BANKS  one-hot-or-zero write enable per bank.
REQ-010 bank_rd_en  output  NUM_BANKS  one-hot-or-zero read enable per bank.
REQ-011 wr_idx / rd_idx  output  IDX_W each  write pointer / read pointer.
REQ-012 rd_last  output  1  high while the draining bank is frame-last marked.
REQ-013 stall_axi_b  output  1  back-pressure to AXI-stream writer.
REQ-014 ready_cnt  output  IDX_W+1  number of banks in READY or DRAINING.

Function
REQ-015 Each bank SHALL hold one state: FREE, FILLING, READY, DRAINING; plus last flag.
REQ-016 bank_wr_en[i] = (state[i]==FILLING); bank_rd_en[i] = (state[i]==DRAINING); both decoded from registers only.
REQ-017 At most one bank FILLING and one bank DRAINING at any time; a bank SHALL never be both enabled.
REQ-018 done_wr with bank[wr_idx] FILLING: bank -> READY, last flag <= tlast, wr_idx <= (wr_idx+1) mod NUM_BANKS, same edge.
REQ-019 Same edge, next write bank -> FILLING if FREE, or if done_rd frees it that edge.
REQ-020 Any cycle bank[wr_idx]==FREE: it SHALL become FILLING on the next edge.
REQ-021 done_wr with no bank FILLING SHALL be ignored (no state change).
REQ-022 bank[rd_idx]==READY at a cycle SHALL become DRAINING on next edge (one-cycle latency).
REQ-023 done_rd with bank[rd_idx] DRAINING: bank -> FREE (or FILLING per REQ-019), last flag cleared, rd_idx increments mod NUM_BANKS; done_rd otherwise ignored.
REQ-024 Pointer wrap: NUM_BANKS-1 SHALL advance to 0.
REQ-025 Early-stall flag: set on done_wr_early when bank[(wr_idx+1) mod NUM_BANKS] != FREE and no done_rd frees it that edge; cleared on done_wr or when that bank becomes FREE.
REQ-026 stall_axi_b = early-stall flag OR no bank FILLING.
REQ-027 rd_last = OR over banks of (DRAINING AND last flag).
REQ-028 ready_cnt SHALL equal count of READY plus DRAINING banks, updated each edge.
REQ-029 Simultaneous done_wr, done_rd, done_wr_early SHALL all be applied in the same edge.

Reset
REQ-030 On rst: bank 0 FILLING, others FREE, all last flags 0, wr_idx=rd_idx=0, early-stall flag 0.
REQ-031 Reset outputs: bank_wr_en=1 (bit 0), bank_rd_en=0, stall_axi_b=0, rd_last=0, ready_cnt=0.
REQ-032 rst mid-operation SHALL discard all bank contents status and override all inputs that cycle.

Configuration
REQ-033 Macro MBBC_ERR_STATUS_EN defined: adds outputs err_sticky (1) and err_cnt (16, saturating at 16'hFFFF); each ignored done_wr or done_rd increments err_cnt and sets err_sticky; both cleared only by rst.
REQ-034 Macro undefined: ports err_sticky and err_cnt SHALL not exist, no added logic; all other behaviour identical.

Verification
REQ-035 NUM_BANKS=2, reset, done_wr -> bank_wr_en=2'b10, next cycle bank_rd_en=2'b01, ready_cnt=1.
REQ-036 NUM_BANKS=4, four done_wr, no done_rd -> after fourth, bank_wr_en=0, stall_axi_b=1, ready_cnt=4; then done_rd -> bank 0 FILLING same edge, stall_axi_b=0.
REQ-037 NUM_BANKS=2, bank 1 READY, done_wr_early -> stall_axi_b=1 next cycle; done_rd frees bank 1 -> stall_axi_b=0 next cycle.
REQ-038 NUM_BANKS=3, done_wr with tlast=1 -> rd_last=1 during that bank's DRAINING, 0 after its done_rd.
REQ-039 NUM_BANKS=8, 20 write/read cycles -> wr_idx and rd_idx wrap 7->0; no cycle with two FILLING or two DRAINING banks.
REQ-040 MBBC_ERR_STATUS_EN defined, done_rd with no bank DRAINING -> err_sticky=1, err_cnt=1; rst -> both 0.
